// File: rtl/accum_unit.sv
// accum_unit: streaming accumulator behind an ALU tile.
// Sums ACC_LEN signed 32-bit samples (wrapping or saturating) and emits the
// total on acc_out with a one-cycle out_valid pulse. Supports early flush and
// synchronous clear. All outputs are registered.
module accum_unit #(
    parameter int ACC_LEN  = 4,   // samples per result, 1..255
    parameter int SATURATE = 0    // 0: wrap mod 2^32, 1: signed saturation
) (
    input  logic        clk,
    input  logic        rst,      // async, active-low
    input  logic        en,
    input  logic [31:0] acc_in,
    input  logic        clr,
    input  logic        flush,
    output logic [31:0] acc_out,
    output logic        out_valid,
    output logic        busy,
    output logic [7:0]  count
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    localparam logic [8:0] LEN = 9'(ACC_LEN);

    logic [0:0]  state;
    logic [31:0] sum;
    logic [32:0] add_full;
    logic        ovf;
    logic [31:0] nxt;
    logic [8:0]  cnt_inc;
    logic        last;

    // Next partial sum: sign-extended add, clamp on signed overflow if enabled.
    always_comb begin
        add_full = {sum[31], sum} + {acc_in[31], acc_in};
        ovf      = add_full[32] ^ add_full[31];
        nxt      = add_full[31:0];
        if (SATURATE != 0 && ovf)
            nxt = add_full[32] ? 32'h8000_0000 : 32'h7fff_ffff;
        cnt_inc  = {1'b0, count} + 9'd1;
        last     = (cnt_inc == LEN);
    end

    // Window state machine; clr beats en and flush, a sample is folded in
    // before a same-cycle flush emits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sum       <= '0;
            count     <= '0;
            acc_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (clr) begin
                state <= IDLE;
                sum   <= '0;
                count <= '0;
            end else if (en) begin
                if (last || flush) begin
                    acc_out   <= nxt;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                    sum       <= '0;
                    count     <= '0;
                end else begin
                    state <= ACCUM;
                    sum   <= nxt;
                    count <= cnt_inc[7:0];
                end
            end else if (flush && state == ACCUM) begin
                acc_out   <= sum;
                out_valid <= 1'b1;
                state     <= IDLE;
                sum       <= '0;
                count     <= '0;
            end
        end
    end

    assign busy = (state == ACCUM);

endmodule

// File: tb/tb_accum_unit.sv
// Directed bench for accum_unit: wrap vs saturate, flush, clear, async reset,
// and the single-sample window configuration.
module tb_accum_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, clr = 1'b0, flush = 1'b0;
    logic [31:0] acc_in = '0;
    logic        en2 = 1'b0;
    logic [31:0] in2 = '0;
    logic        zero = 1'b0;

    logic [31:0] ao0, ao1, ao2;
    logic        ov0, ov1, ov2, bz0, bz1, bz2;
    logic [7:0]  ct0, ct1, ct2;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    accum_unit #(.ACC_LEN(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .acc_in(acc_in), .clr(clr), .flush(flush),
        .acc_out(ao0), .out_valid(ov0), .busy(bz0), .count(ct0));

    accum_unit #(.ACC_LEN(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .acc_in(acc_in), .clr(clr), .flush(flush),
        .acc_out(ao1), .out_valid(ov1), .busy(bz1), .count(ct1));

    accum_unit #(.ACC_LEN(1), .SATURATE(0)) u_one (
        .clk(clk), .rst(rst), .en(en2), .acc_in(in2), .clr(zero), .flush(zero),
        .acc_out(ao2), .out_valid(ov2), .busy(bz2), .count(ct2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // advance one rising edge, settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] v);
        en = 1'b1; acc_in = v;
        step();
        en = 1'b0; acc_in = '0;
    endtask

    function automatic logic [31:0] b(input logic x);
        return {31'b0, x};
    endfunction

    function automatic logic [31:0] c8(input logic [7:0] x);
        return {24'b0, x};
    endfunction

    initial begin
        logic [7:0] exp_cnt [8];
        exp_cnt = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};

        // reset state
        #3;
        chk("rst_acc", ao0, 32'h0);
        chk("rst_vld", b(ov0), 32'h0);
        chk("rst_busy", b(bz0), 32'h0);
        chk("rst_cnt", c8(ct0), 32'h0);
        step(); step();
        rst = 1'b1;

        // stream 1..8 at full rate
        for (int i = 0; i < 8; i++) begin
            en = 1'b1; acc_in = 32'(i + 1);
            step();
            chk($sformatf("cnt%0d", i), c8(ct0), c8(exp_cnt[i]));
            chk($sformatf("vld%0d", i), b(ov0), b(i == 3 || i == 7));
            if (i == 3) chk("sum10", ao0, 32'd10);
            if (i == 4) chk("hold10", ao0, 32'd10);
            if (i == 7) chk("sum26", ao0, 32'd26);
        end
        en = 1'b0; acc_in = '0;
        step();
        chk("vld_drop", b(ov0), 32'h0);

        // positive overflow: wrap vs saturate
        feed(32'h7fff_ffff); feed(32'h1); feed(32'h0); feed(32'h0);
        chk("wrap_pos", ao0, 32'h8000_0000);
        chk("sat_pos", ao1, 32'h7fff_ffff);
        chk("sat_pos_vld", b(ov1), 32'h1);
        // negative overflow
        feed(32'h8000_0000); feed(32'hffff_ffff); feed(32'h0); feed(32'h0);
        chk("wrap_neg", ao0, 32'h7fff_ffff);
        chk("sat_neg", ao1, 32'h8000_0000);

        // flush in ACCUM with en=0
        feed(32'd5); feed(32'd5);
        chk("fl_busy", b(bz0), 32'h1);
        chk("fl_cnt", c8(ct0), 32'd2);
        flush = 1'b1; step(); flush = 1'b0;
        chk("fl_acc", ao0, 32'd10);
        chk("fl_vld", b(ov0), 32'h1);
        chk("fl_idle", b(bz0), 32'h0);
        // flush in IDLE does nothing
        flush = 1'b1; step(); flush = 1'b0;
        chk("fl2_vld", b(ov0), 32'h0);
        chk("fl2_acc", ao0, 32'd10);

        // flush together with a sample: sample included first
        feed(32'd3);
        flush = 1'b1; feed(32'd4); flush = 1'b0;
        chk("fle_acc", ao0, 32'd7);
        chk("fle_vld", b(ov0), 32'h1);
        chk("fle_cnt", c8(ct0), 32'h0);

        // clear with simultaneous sample discards everything
        feed(32'd7); feed(32'd7);
        clr = 1'b1; feed(32'd100); clr = 1'b0;
        chk("clr_cnt", c8(ct0), 32'h0);
        chk("clr_busy", b(bz0), 32'h0);
        chk("clr_vld", b(ov0), 32'h0);
        chk("clr_acc", ao0, 32'd7);
        feed(32'd1); feed(32'd1); feed(32'd1);
        chk("clr_hold", ao0, 32'd7);
        feed(32'd1);
        chk("clr_res", ao0, 32'd4);
        chk("clr_res_vld", b(ov0), 32'h1);

        // async reset mid-window
        feed(32'd20); feed(32'd6); feed(32'd0); feed(32'd0);
        chk("pre_rst_acc", ao0, 32'd26);
        feed(32'd1); feed(32'd1);
        chk("pre_rst_cnt", c8(ct0), 32'd2);
        #2 rst = 1'b0;
        #1;
        chk("arst_acc", ao0, 32'h0);
        chk("arst_cnt", c8(ct0), 32'h0);
        chk("arst_busy", b(bz0), 32'h0);
        chk("arst_vld", b(ov0), 32'h0);
        #1 rst = 1'b1;
        feed(32'd2); feed(32'd2); feed(32'd2); feed(32'd2);
        chk("post_rst", ao0, 32'd8);
        chk("post_rst_vld", b(ov0), 32'h1);

        // single-sample windows: echo with gaps
        en2 = 1'b1; in2 = 32'hffff_fffd; step(); en2 = 1'b0;
        chk("one_a", ao2, 32'hffff_fffd);
        chk("one_a_vld", b(ov2), 32'h1);
        chk("one_a_busy", b(bz2), 32'h0);
        step();
        chk("one_gap_vld", b(ov2), 32'h0);
        chk("one_gap_busy", b(bz2), 32'h0);
        step();
        en2 = 1'b1; in2 = 32'd9; step(); en2 = 1'b0;
        chk("one_b", ao2, 32'd9);
        chk("one_b_vld", b(ov2), 32'h1);
        chk("one_b_busy", b(bz2), 32'h0);
        step();
        chk("one_b_drop", b(ov2), 32'h0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
